// File: rtl/freq_div_ctl.sv
// Parametrised clock divider and timing generator. It produces a divided clock level,
// a one-cycle tick at each wrap of the main counter, and a free-running scan select.
module freq_div_ctl #(
   parameter int unsigned CNT_W      = 27,
   parameter int unsigned SCAN_CNT_W = 17,
   parameter int unsigned SCAN_W     = 2,
   parameter int unsigned DEF_DIV    = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              div_load,
   input  logic [CNT_W-1:0]  div_val,
   output logic              clk_out,
   output logic              tick,
   output logic [SCAN_W-1:0] clk_ctl
);

   localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      div_reg_q, div_reg_d;
   logic [SCAN_CNT_W-1:0] scan_q, scan_d;
   logic                  clk_out_q, clk_out_d;
   logic                  tick_q, tick_d;
   logic                  mode_q, mode_d;
   logic [CNT_W-1:0]      div_eff;
   logic [CNT_W-1:0]      cnt_inc;

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         div_reg_q <= CNT_W'(DEF_DIV);
         scan_q    <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_reg_q <= div_reg_d;
         scan_q    <= scan_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         mode_q    <= mode_d;
      end
   end

   // Next-state logic. A divisor of zero behaves the same as a divisor of one.
   always_comb begin
      cnt_d     = cnt_q;
      div_reg_d = div_reg_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      mode_d    = mode_q;
      scan_d    = scan_q + SCAN_CNT_W'(1);
      div_eff   = (div_reg_q == '0) ? CNT_W'(1) : div_reg_q;
      cnt_inc   = cnt_q + CNT_W'(1);

      if (div_load) begin
         div_reg_d = div_val;
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (mode != mode_q) begin
         mode_d    = mode;
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (en) begin
         if (!mode_q) begin
            // Binary mode: clk_out tracks the counter MSB one register stage ahead.
            cnt_d     = cnt_inc;
            clk_out_d = cnt_inc[CNT_W-1];
            tick_d    = (cnt_q == CNT_ONES);
         end else if (cnt_q == div_eff - CNT_W'(1)) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
         end else begin
            cnt_d     = cnt_inc;
         end
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign clk_ctl = scan_q[SCAN_CNT_W-1 -: SCAN_W];

endmodule

// File: tb/tb_freq_div_ctl.sv
// Testbench for freq_div_ctl using directed scenarios and randomized stimulus.
// Every output is compared each cycle against a behavioural model.
module tb_freq_div_ctl;

   localparam int unsigned CNT_W      = 4;
   localparam int unsigned SCAN_CNT_W = 3;
   localparam int unsigned SCAN_W     = 2;
   localparam int unsigned DEF_DIV    = 5;
   localparam int          CNT_MOD    = 1 << CNT_W;
   localparam int          SCAN_MOD   = 1 << SCAN_CNT_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              mode;
   logic              div_load;
   logic [CNT_W-1:0]  div_val;
   logic              clk_out;
   logic              tick;
   logic [SCAN_W-1:0] clk_ctl;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, kept as plain integers.
   int m_cnt, m_div, m_scan, m_clk, m_tick, m_mode;

   freq_div_ctl #(
      .CNT_W(CNT_W), .SCAN_CNT_W(SCAN_CNT_W), .SCAN_W(SCAN_W), .DEF_DIV(DEF_DIV)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .div_load(div_load),
      .div_val(div_val), .clk_out(clk_out), .tick(tick), .clk_ctl(clk_ctl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_div = DEF_DIV; m_scan = 0; m_clk = 0; m_tick = 0; m_mode = 0;
   endtask

   // One rising edge of the model, using the rules in priority order.
   task automatic model_clock();
      int d;
      m_scan = (m_scan + 1) % SCAN_MOD;
      m_tick = 0;
      if (div_load) begin
         m_div = int'(div_val); m_cnt = 0; m_clk = 0;
      end else if (int'(mode) != m_mode) begin
         m_mode = int'(mode); m_cnt = 0; m_clk = 0;
      end else if (en) begin
         if (m_mode == 0) begin
            m_tick = (m_cnt == CNT_MOD - 1) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % CNT_MOD;
            m_clk  = (m_cnt >= CNT_MOD / 2) ? 1 : 0;
         end else begin
            d = (m_div == 0) ? 1 : m_div;
            if (m_cnt == d - 1) begin
               m_cnt = 0; m_clk = 1 - m_clk; m_tick = 1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".clk_out"}, int'(clk_out), m_clk);
      check({tag, ".tick"},    int'(tick),    m_tick);
      check({tag, ".clk_ctl"}, int'(clk_ctl), m_scan / (SCAN_MOD / (1 << SCAN_W)));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check_outputs(tag);
   endtask

   // Counts edges until the DUT raises tick; an expired budget shows up as a wrong count.
   task automatic wait_tick(input string tag, input int exp, input int budget);
      int n = 0;
      do begin
         step(tag);
         n++;
      end while (tick !== 1'b1 && n < budget);
      check({tag, ".edges"}, n, exp);
   endtask

   // Asynchronous reset pulse between edges; the outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_outputs(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_val = '0;
      model_reset();
      #1;
      check_outputs("reset");
      #11 rst = 1'b0;

      // Scan counter with counting disabled.
      for (int i = 0; i < 16; i++) step("scan");

      // Binary mode, mid-run reset, then full period timing.
      en = 1'b1;
      for (int i = 0; i < 11; i++) step("bin_pre");
      async_reset("bin_rst");
      wait_tick("bin_first", 16, 40);
      wait_tick("bin_gap", 16, 40);

      // Programmable mode with the reset divisor.
      mode = 1'b1;
      wait_tick("prog_first", 6, 40);
      wait_tick("prog_gap1", 5, 40);
      wait_tick("prog_gap2", 5, 40);

      // Load a new divisor while cnt is 3.
      for (int i = 0; i < 3; i++) step("load_pre");
      check("load_pre.cnt", m_cnt, 3);
      div_val = CNT_W'(3); div_load = 1'b1;
      step("load_edge");
      div_load = 1'b0;
      check("load_edge.tick", int'(tick), 0);
      wait_tick("load_first", 3, 40);
      wait_tick("load_gap", 3, 40);

      // Divisors of zero and one behave identically.
      for (int v = 0; v < 2; v++) begin
         div_val = CNT_W'(v); div_load = 1'b1;
         step("degen_load");
         div_load = 1'b0;
         for (int i = 0; i < 6; i++) begin
            step("degen");
            check("degen.tick_high", int'(tick), 1);
         end
      end

      // Pause at cnt=2 with a divisor of 5.
      div_val = CNT_W'(5); div_load = 1'b1;
      step("pause_load");
      div_load = 1'b0;
      for (int i = 0; i < 2; i++) step("pause_pre");
      en = 1'b0;
      for (int i = 0; i < 7; i++) step("pause");
      check("pause.cnt", m_cnt, 2);
      en = 1'b1;
      wait_tick("pause_resume", 5 - 2, 40);

      // Randomized stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         en       = ($urandom_range(99) < 85);
         div_load = ($urandom_range(99) < 3);
         div_val  = CNT_W'($urandom_range(CNT_MOD - 1));
         if ($urandom_range(99) < 2) mode = ~mode;
         step("rand");
         if ($urandom_range(999) < 3) async_reset("rand_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
